shift_register_multi: RTL

Parametrised successor to the fixed 8-stage, 1-bit serial shift register. It is a DEPTH-stage, WIDTH-bit-per-stage shift chain with the following features:
- shift enable, selectable direction, synchronous clear and parallel load/readout;
- a fill counter that indicates when the exit stage holds shifted-in data.

It is used as a delay line, serial-to-parallel converter or parallel-to-serial converter in datapath and scan-style blocks.

---
 rtl/shift_register_multi.sv | 68 ++++++
 1 files changed

// File: rtl/shift_register_multi.sv
// DEPTH-stage, WIDTH-bit shift chain with bidirectional shift, synchronous clear,
// parallel load/readout and a saturating fill counter.
module shift_register_multi #(
    parameter  int unsigned WIDTH = 1,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic                   C,
    input  logic                   RN,
    input  logic                   CLR,
    input  logic                   LD,
    input  logic                   EN,
    input  logic                   DIR,
    input  logic [WIDTH-1:0]       SI,
    input  logic [WIDTH*DEPTH-1:0] PI,
    output logic [WIDTH-1:0]       SO,
    output logic [WIDTH-1:0]       SOL,
    output logic [WIDTH*DEPTH-1:0] PO,
    output logic [CW-1:0]          FILL,
    output logic                   FULL
);

    localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

    // Stage k occupies bits [k*WIDTH +: WIDTH] when flattened, matching PI/PO packing.
    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
    logic [CW-1:0]               fill_q, fill_d;

    // Next-state: CLR > LD > EN > hold.
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        if (CLR) begin
            stage_d = '0;
            fill_d  = '0;
        end else if (LD) begin
            stage_d = PI;
            fill_d  = FILL_MAX;
        end else if (EN) begin
            if (!DIR) begin
                stage_d = {stage_q[DEPTH-2:0], SI};
            end else begin
                stage_d = {SI, stage_q[DEPTH-1:1]};
            end
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + CW'(1);
            end
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            stage_q <= '0;
            fill_q  <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs are direct decodes of the state registers.
    assign PO   = stage_q;
    assign SO   = stage_q[DEPTH-1];
    assign SOL  = stage_q[0];
    assign FILL = fill_q;
    assign FULL = (fill_q == FILL_MAX);

endmodule
